// File: rtl/synth_tick_pkg.sv
// Shared types and helpers for the synth tick generator.
package synth_tick_pkg;

   localparam int unsigned DEF_ACC_WIDTH   = 24;
   localparam int unsigned DEF_DATA_WIDTH  = 16;
   localparam int unsigned DEF_CHANNEL_NUM = 2;

   // Phase increment at the default accumulator width.
   typedef logic [DEF_ACC_WIDTH-1:0] inc_t;

   // Audio bits per frame at the default framing.
   localparam int unsigned BITS_PER_FRAME = DEF_DATA_WIDTH * DEF_CHANNEL_NUM;

   // Index width for a range of 'depth' entries; never returns less than 1.
   function automatic int unsigned clogb2(input int unsigned depth);
      int unsigned w;
      int unsigned v;
      w = 0;
      v = (depth > 1) ? depth - 1 : 1;
      while (v > 0) begin
         w++;
         v = v >> 1;
      end
      return w;
   endfunction

   // Audio bits per frame for an arbitrary framing.
   function automatic int unsigned bits_per_frame(input int unsigned data_width,
                                                  input int unsigned channel_num);
      return data_width * channel_num;
   endfunction

endpackage

// File: rtl/synth_nco_tick.sv
// One NCO channel: phase accumulator, double-buffered increment, tick and square.
module synth_nco_tick
   import synth_tick_pkg::*;
#(
   parameter int unsigned ACC_WIDTH = 24
) (
   input  logic                 i_clk,
   input  logic                 i_rst_n,
   input  logic                 i_run,
   input  logic                 i_wr,
   input  logic [ACC_WIDTH-1:0] i_wr_data,
   output logic                 o_tick,
   output logic                 o_sq,
   output logic                 o_fall
);

   logic [ACC_WIDTH-1:0] r_acc;
   logic [ACC_WIDTH-1:0] r_inc_act;
   logic [ACC_WIDTH-1:0] r_inc_pend;
   logic                 r_tick;
   logic                 r_sq;
   logic [ACC_WIDTH:0]   w_sum;
   logic                 w_carry;
   logic                 w_load;

   // Overflowing add; active increment reloads only at a wrap or while halted.
   always_comb begin
      w_sum   = {1'b0, r_acc} + {1'b0, r_inc_act};
      w_carry = i_run & w_sum[ACC_WIDTH];
      w_load  = w_carry | (r_inc_act == '0);
   end

   // Increment registers: pending takes writes, active copies the pre-write pending.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_inc_pend <= '0;
         r_inc_act  <= '0;
      end else begin
         if (i_wr) begin
            r_inc_pend <= i_wr_data;
         end
         if (w_load) begin
            r_inc_act <= r_inc_pend;
         end
      end
   end

   // Phase accumulator, tick strobe and square toggle; run low clears.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_acc  <= '0;
         r_tick <= 1'b0;
         r_sq   <= 1'b0;
      end else if (!i_run) begin
         r_acc  <= '0;
         r_tick <= 1'b0;
         r_sq   <= 1'b0;
      end else begin
         r_acc  <= w_sum[ACC_WIDTH-1:0];
         r_tick <= w_carry;
         if (w_carry) begin
            r_sq <= ~r_sq;
         end
      end
   end

   assign o_tick = r_tick;
   assign o_sq   = r_sq;
   // Carry that will drive the square low: the bit-clock falling edge.
   assign o_fall = w_carry & r_sq;

endmodule

// File: rtl/synth_tick_gen.sv
// Multi-channel NCO tick generator with audio bit/word/sample framing on channel 0.
module synth_tick_gen
   import synth_tick_pkg::*;
#(
   parameter int unsigned NUM_TICKS   = 3,
   parameter int unsigned ACC_WIDTH   = 24,
   parameter int unsigned DATA_WIDTH  = 16,
   parameter int unsigned CHANNEL_NUM = 2
) (
   input  logic                           OSC_CLK,
   input  logic                           reset_reg_N,
   input  logic                           run,
   input  logic                           inc_wr,
   input  logic [clogb2(NUM_TICKS)-1:0]   inc_sel,
   input  logic [ACC_WIDTH-1:0]           inc_data,
   output logic [NUM_TICKS-1:0]           tick,
   output logic [NUM_TICKS-1:0]           sq,
   output logic                           oAUD_BCK,
   output logic                           LRCK_1X,
   output logic                           sample_tick
);

   localparam int unsigned SEL_W  = clogb2(NUM_TICKS);
   localparam int unsigned BIT_W  = clogb2(DATA_WIDTH);
   localparam int unsigned SLOT_W = clogb2(CHANNEL_NUM);

   logic [NUM_TICKS-1:0] w_wr;
   logic [NUM_TICKS-1:0] w_tick;
   logic [NUM_TICKS-1:0] w_sq;
   logic [NUM_TICKS-1:0] w_fall;
   logic [BIT_W-1:0]     r_bit_cnt;
   logic [SLOT_W-1:0]    r_slot_cnt;
   logic                 r_lrck;
   logic                 r_sample_tick;

   for (genvar k = 0; k < NUM_TICKS; k++) begin : g_ch
      // Write decode; selects beyond NUM_TICKS-1 match no channel.
      always_comb begin
         w_wr[k] = inc_wr & (inc_sel == SEL_W'(k));
      end

      synth_nco_tick #(
         .ACC_WIDTH (ACC_WIDTH)
      ) u_nco (
         .i_clk     (OSC_CLK),
         .i_rst_n   (reset_reg_N),
         .i_run     (run),
         .i_wr      (w_wr[k]),
         .i_wr_data (inc_data),
         .o_tick    (w_tick[k]),
         .o_sq      (w_sq[k]),
         .o_fall    (w_fall[k])
      );
   end

   // Bit/slot counters advance on BCK falling edges; same edge as the square update.
   always_ff @(posedge OSC_CLK or negedge reset_reg_N) begin
      if (!reset_reg_N) begin
         r_bit_cnt     <= '0;
         r_slot_cnt    <= '0;
         r_lrck        <= 1'b0;
         r_sample_tick <= 1'b0;
      end else if (!run) begin
         r_bit_cnt     <= '0;
         r_slot_cnt    <= '0;
         r_lrck        <= 1'b0;
         r_sample_tick <= 1'b0;
      end else begin
         r_sample_tick <= 1'b0;
         if (w_fall[0]) begin
            if (r_bit_cnt == BIT_W'(DATA_WIDTH - 1)) begin
               r_bit_cnt <= '0;
               r_lrck    <= ~r_lrck;
               if (r_slot_cnt == SLOT_W'(CHANNEL_NUM - 1)) begin
                  r_slot_cnt    <= '0;
                  r_sample_tick <= 1'b1;
               end else begin
                  r_slot_cnt <= r_slot_cnt + SLOT_W'(1);
               end
            end else begin
               r_bit_cnt <= r_bit_cnt + BIT_W'(1);
            end
         end
      end
   end

   assign tick        = w_tick;
   assign sq          = w_sq;
   assign oAUD_BCK    = w_sq[0];
   assign LRCK_1X     = r_lrck;
   assign sample_tick = r_sample_tick;

endmodule

// File: tb/tb_synth_tick_gen.sv
// Directed self-checking bench for synth_tick_gen (ACC_WIDTH=8, DATA_WIDTH=4, CHANNEL_NUM=2).
module tb_synth_tick_gen;

   logic       OSC_CLK;
   logic       reset_reg_N;
   logic       run;
   logic       inc_wr;
   logic [1:0] inc_sel;
   logic [7:0] inc_data;
   logic [2:0] tick;
   logic [2:0] sq;
   logic       oAUD_BCK;
   logic       LRCK_1X;
   logic       sample_tick;

   int n_checks = 0;
   int n_fail   = 0;

   synth_tick_gen #(
      .NUM_TICKS   (3),
      .ACC_WIDTH   (8),
      .DATA_WIDTH  (4),
      .CHANNEL_NUM (2)
   ) dut (
      .OSC_CLK     (OSC_CLK),
      .reset_reg_N (reset_reg_N),
      .run         (run),
      .inc_wr      (inc_wr),
      .inc_sel     (inc_sel),
      .inc_data    (inc_data),
      .tick        (tick),
      .sq          (sq),
      .oAUD_BCK    (oAUD_BCK),
      .LRCK_1X     (LRCK_1X),
      .sample_tick (sample_tick)
   );

   initial OSC_CLK = 1'b0;
   always #5 OSC_CLK = ~OSC_CLK;

   task automatic check_val(input string tag, input int got, input int exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   // Advance one active edge and settle just after it.
   task automatic step();
      @(posedge OSC_CLK);
      #1;
   endtask

   task automatic do_reset();
      reset_reg_N = 1'b0;
      run         = 1'b0;
      inc_wr      = 1'b0;
      step();
      step();
      reset_reg_N = 1'b1;
      step();
   endtask

   // Write with run low, then one idle edge so a halted channel picks it up.
   task automatic wr(input int sel, input logic [7:0] data);
      inc_wr   = 1'b1;
      inc_sel  = 2'(sel);
      inc_data = data;
      step();
      inc_wr = 1'b0;
      step();
   endtask

   task automatic check_all_zero(input string tag);
      check_val({tag, "_tick"}, int'(tick), 0);
      check_val({tag, "_sq"}, int'(sq), 0);
      check_val({tag, "_bck"}, int'(oAUD_BCK), 0);
      check_val({tag, "_lrck"}, int'(LRCK_1X), 0);
      check_val({tag, "_stick"}, int'(sample_tick), 0);
   endtask

   // Count edges with run high; optional write sampled at edge wn; mask bit e = tick expected after edge e.
   task automatic run_ch(input int ch, input int wsel, input int n, input int wn,
                         input logic [7:0] wdata, input logic [63:0] mask, input string tag);
      int cnt;
      cnt = 0;
      run = 1'b1;
      for (int e = 1; e <= n; e++) begin
         if (e == wn) begin
            inc_wr   = 1'b1;
            inc_sel  = 2'(wsel);
            inc_data = wdata;
         end
         step();
         inc_wr = 1'b0;
         if (mask[e]) cnt++;
         check_val($sformatf("%s_tick@%0d", tag, e), int'(tick[ch]), int'(mask[e]));
         check_val($sformatf("%s_sq@%0d", tag, e), int'(sq[ch]), cnt % 2);
      end
   endtask

   // Channel 0 at inc=128: BCK period 4, LRCK toggles every 16, sample strobe every 32.
   task automatic frame_chk(input int n, input string tag);
      run = 1'b1;
      for (int e = 1; e <= n; e++) begin
         step();
         check_val($sformatf("%s_tick0@%0d", tag, e), int'(tick[0]), (e % 2 == 0) ? 1 : 0);
         check_val($sformatf("%s_bck@%0d", tag, e), int'(oAUD_BCK), (e / 2) % 2);
         check_val($sformatf("%s_lrck@%0d", tag, e), int'(LRCK_1X), (e / 16) % 2);
         check_val($sformatf("%s_stick@%0d", tag, e), int'(sample_tick), (e % 32 == 0) ? 1 : 0);
      end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      reset_reg_N = 1'b0;
      run         = 1'b0;
      inc_wr      = 1'b0;
      inc_sel     = '0;
      inc_data    = '0;

      // Reset state
      do_reset();
      check_all_zero("reset");

      // Integer rate: inc=64 -> tick every 4 edges starting at the 4th
      wr(1, 8'd64);
      run_ch(1, 1, 24, 0, 8'd0, 64'h0000_0000_0111_1110, "int64");

      // Fractional rate: inc=96 -> ticks where floor(3e/8) steps (intervals 3,3,2)
      run = 1'b0;
      step();
      check_all_zero("runclr");
      wr(2, 8'd96);
      run_ch(2, 2, 63, 0, 8'd0, 64'h4949_4949_4949_4948, "frac96");

      // Mid-period reprogram 64 -> 128: old interval completes at edge 8, then every 2
      do_reset();
      wr(1, 8'd64);
      run_ch(1, 1, 16, 6, 8'd128, 64'h0000_0000_0001_5510, "glitch");

      // Write coincident with the wrap at edge 4 applies only at the wrap at edge 8
      do_reset();
      wr(1, 8'd64);
      run_ch(1, 1, 16, 4, 8'd128, 64'h0000_0000_0001_5510, "coinc");

      // Out-of-range select has no effect
      do_reset();
      wr(1, 8'd64);
      run_ch(1, 3, 16, 2, 8'd128, 64'h0000_0000_0001_1110, "oor");
      check_val("oor_other_ch", int'({tick[2], tick[0]}), 0);

      // inc=255: tick every edge except edge 1 and edge 257
      do_reset();
      wr(1, 8'd255);
      run = 1'b1;
      for (int e = 1; e <= 260; e++) begin
         step();
         check_val($sformatf("inc255_tick@%0d", e), int'(tick[1]), (e == 1 || e == 257) ? 0 : 1);
      end

      // Audio framing, drop run mid-frame, restart from bit 0
      do_reset();
      wr(0, 8'd128);
      frame_chk(22, "frameA");
      run = 1'b0;
      step();
      check_all_zero("rundrop");
      frame_chk(50, "frameB");

      // Asynchronous reset between edges clears outputs at once
      #2;
      reset_reg_N = 1'b0;
      #1;
      check_all_zero("async_rst");
      step();
      reset_reg_N = 1'b1;
      run = 1'b1;
      for (int e = 1; e <= 8; e++) begin
         step();
         check_val($sformatf("post_rst_tick@%0d", e), int'(tick), 0);
         check_val($sformatf("post_rst_sq@%0d", e), int'(sq), 0);
      end

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule
